// File: rtl/operand_extend_stage_pkg.sv
// Shared constants for the operand-extension stage: access modes, operand
// type encoding and default geometry.
package operand_extend_stage_pkg;

   // Register access modes carried in the top two bits of a register operand
   typedef enum logic [1:0] {
      MODE_DIRECT   = 2'b00,
      MODE_INDIRECT = 2'b01,
      MODE_POSTINC  = 2'b10,
      MODE_PREDEC   = 2'b11
   } mode_e;

   // Per-operand type bit as delivered by decode
   typedef enum logic {
      OPTYPE_IMM = 1'b0,
      OPTYPE_REG = 1'b1
   } optype_e;

   localparam int DEF_NUM_OPS  = 3;
   localparam int DEF_OP_W     = 8;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 64;

endpackage

// File: rtl/operand_extend_stage_unit.sv
// Combinational single-operand extender: register operands split into
// mode + zero-extended index with a range check, immediates sign-extend.
module operand_extend_unit
   import operand_extend_stage_pkg::*;
#(
   parameter int OP_W     = DEF_OP_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic [OP_W-1:0]   op,
   input  logic              isreg,
   output logic [DATA_W-1:0] ext,
   output logic [1:0]        mode,
   output logic              regerr
);

   localparam int IDX_W = OP_W - 2;
   // One extra bit so NUM_REGS == 2**IDX_W is representable
   localparam logic [IDX_W:0] NUM_REGS_V = NUM_REGS[IDX_W:0];

   logic [IDX_W-1:0] idx;
   assign idx = op[IDX_W-1:0];

   // Select register split or immediate sign extension
   always_comb begin
      ext    = '0;
      mode   = MODE_DIRECT;
      regerr = 1'b0;
      if (isreg == OPTYPE_REG) begin
         ext    = DATA_W'(idx);
         mode   = op[OP_W-1 -: 2];
         regerr = ({1'b0, idx} >= NUM_REGS_V);
      end else begin
         ext    = DATA_W'($signed(op));
      end
   end

endmodule

// File: rtl/operand_extend_stage.sv
// Operand-extension stage: NUM_OPS parallel extenders feeding a 2-entry
// valid/ready buffer. in_ready depends only on the fill count, so there
// is no combinational path from out_ready back to decode.
module operand_extend_stage
   import operand_extend_stage_pkg::*;
#(
   parameter int NUM_OPS  = DEF_NUM_OPS,
   parameter int OP_W     = DEF_OP_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_OPS-1:0]        in_optype,
   input  logic [NUM_OPS*OP_W-1:0]   in_ops,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [NUM_OPS*2-1:0]      out_mode,
   output logic [NUM_OPS-1:0]        out_isreg,
   output logic [NUM_OPS-1:0]        out_regerr,
   output logic [1:0]                occupancy
);

   logic [NUM_OPS*DATA_W-1:0] ext_ops;
   logic [NUM_OPS*2-1:0]      ext_mode;
   logic [NUM_OPS-1:0]        ext_regerr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_ext
         operand_extend_unit #(
            .OP_W     (OP_W),
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS)
         ) u_ext (
            .op     (in_ops[gi*OP_W +: OP_W]),
            .isreg  (in_optype[gi]),
            .ext    (ext_ops[gi*DATA_W +: DATA_W]),
            .mode   (ext_mode[gi*2 +: 2]),
            .regerr (ext_regerr[gi])
         );
      end
   endgenerate

   logic [NUM_OPS*DATA_W-1:0] ops_mem    [2];
   logic [NUM_OPS*2-1:0]      mode_mem   [2];
   logic [NUM_OPS-1:0]        isreg_mem  [2];
   logic [NUM_OPS-1:0]        regerr_mem [2];

   logic       wr_ptr_reg, wr_ptr_next;
   logic       rd_ptr_reg, rd_ptr_next;
   logic [1:0] count_reg, count_next;
   logic       push, pop;

   assign in_ready  = (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_ops    = ops_mem[rd_ptr_reg];
   assign out_mode   = mode_mem[rd_ptr_reg];
   assign out_isreg  = isreg_mem[rd_ptr_reg];
   assign out_regerr = regerr_mem[rd_ptr_reg];
   assign occupancy  = count_reg;

   // Next pointer/count values; simultaneous push and pop keep the count
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Entry storage: written only on push, so idle inputs never reach it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < 2; e++) begin
            ops_mem[e]    <= '0;
            mode_mem[e]   <= '0;
            isreg_mem[e]  <= '0;
            regerr_mem[e] <= '0;
         end
      end else if (push) begin
         ops_mem[wr_ptr_reg]    <= ext_ops;
         mode_mem[wr_ptr_reg]   <= ext_mode;
         isreg_mem[wr_ptr_reg]  <= in_optype;
         regerr_mem[wr_ptr_reg] <= ext_regerr;
      end
   end

endmodule

// File: tb/tb_operand_extend_stage.sv
// Bench for operand_extend_stage: queue-based reference model checked every
// cycle, plus literal expectations for the directed vectors.
module tb_operand_extend_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default-geometry instance
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  in_optype;
   logic [23:0] in_ops;
   logic [47:0] out_ops;
   logic [5:0]  out_mode;
   logic [2:0]  out_isreg, out_regerr;
   logic [1:0]  occupancy;

   operand_extend_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_optype(in_optype), .in_ops(in_ops),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ops(out_ops), .out_mode(out_mode),
      .out_isreg(out_isreg), .out_regerr(out_regerr),
      .occupancy(occupancy)
   );

   // Wide instance: OP_W=10, DATA_W=32, NUM_OPS=4, NUM_REGS=40
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [3:0]   b_in_optype, b_out_isreg, b_out_regerr;
   logic [39:0]  b_in_ops;
   logic [127:0] b_out_ops;
   logic [7:0]   b_out_mode;
   logic [1:0]   b_occupancy;

   operand_extend_stage #(.NUM_OPS(4), .OP_W(10), .DATA_W(32), .NUM_REGS(40)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_optype(b_in_optype), .in_ops(b_in_ops),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_ops(b_out_ops), .out_mode(b_out_mode),
      .out_isreg(b_out_isreg), .out_regerr(b_out_regerr),
      .occupancy(b_occupancy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Extension rules written as plain arithmetic on integers
   function automatic void ext_model(input int opw, input int dataw, input int nregs,
                                     input int op, input bit isreg,
                                     output longint ext, output int mode, output bit err);
      longint span;
      longint v;
      span = longint'(1) << (opw - 2);
      if (isreg) begin
         mode = int'(op / span);
         ext  = op % span;
         err  = (ext >= nregs);
      end else begin
         v    = (op >= (1 << (opw - 1))) ? longint'(op) - (longint'(1) << opw) : longint'(op);
         ext  = v & ((longint'(1) << dataw) - 1);
         mode = 0;
         err  = 1'b0;
      end
   endfunction

   typedef struct {
      logic [47:0] ops;
      logic [5:0]  mode;
      logic [2:0]  isreg;
      logic [2:0]  regerr;
   } ent_t;

   function automatic ent_t model3(input logic [2:0] optype, input logic [23:0] ops);
      ent_t   e;
      longint x;
      int     m;
      bit     r;
      for (int i = 0; i < 3; i++) begin
         ext_model(8, 16, 64, int'(ops[i*8 +: 8]), optype[i], x, m, r);
         e.ops[i*16 +: 16] = x[15:0];
         e.mode[i*2 +: 2]  = m[1:0];
         e.regerr[i]       = r;
      end
      e.isreg = optype;
      return e;
   endfunction

   ent_t q[$];

   // Reference FIFO: contents in arrival order, capacity two
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         automatic bit pu = in_valid && (q.size() != 2);
         automatic bit po = out_ready && (q.size() != 0);
         if (po) void'(q.pop_front());
         if (pu) q.push_back(model3(in_optype, in_ops));
      end
   end

   // Per-cycle comparison of the default instance against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("occupancy", 64'(occupancy), 64'(q.size()));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
         if (q.size() != 0) begin
            chk("head_ops", 64'(out_ops), 64'(q[0].ops));
            chk("head_mode", 64'(out_mode), 64'(q[0].mode));
            chk("head_isreg", 64'(out_isreg), 64'(q[0].isreg));
            chk("head_regerr", 64'(out_regerr), 64'(q[0].regerr));
         end
      end
   end

   // Handshakes seen on the DUT output, counted away from the clock edge
   int dut_pops = 0;
   always @(negedge clk) if (rst_n && out_valid && out_ready) dut_pops++;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int p0;
      longint x;
      int m;
      bit r;

      in_valid = 0; out_ready = 0; in_optype = '0; in_ops = '0;
      b_in_valid = 0; b_out_ready = 1; b_in_optype = '0; b_in_ops = '0;

      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_ops", 64'(out_ops), 64'd0);
      chk("rst_out_mode", 64'(out_mode), 64'd0);
      chk("rst_out_isreg", 64'(out_isreg), 64'd0);
      chk("rst_out_regerr", 64'(out_regerr), 64'd0);
      rst_n = 1;
      step();

      // Register/immediate mix, 1-cycle latency
      out_ready = 1; in_valid = 1; in_optype = 3'b101; in_ops = 24'h7F_FE_85;
      step();
      in_valid = 0;
      $display("mix: out_ops=%h out_mode=%b", out_ops, out_mode);
      chk("mix_valid", 64'(out_valid), 64'd1);
      chk("mix_ops", 64'(out_ops), 64'h0000_003F_FFFE_0005);
      chk("mix_mode", 64'(out_mode), 64'(6'b01_00_10));
      chk("mix_isreg", 64'(out_isreg), 64'(3'b101));
      step();

      // Backpressure: A and B accepted, C stalls
      out_ready = 0;
      in_valid = 1; in_optype = 3'b010; in_ops = 24'h11_22_33;
      step();
      in_optype = 3'b111; in_ops = 24'hC4_45_06;
      step();
      in_optype = 3'b000; in_ops = 24'h80_7F_01;
      #1;
      $display("bp: occupancy=%0d in_ready=%0d head=%h", occupancy, in_ready, out_ops);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_occupancy", 64'(occupancy), 64'd2);
      chk("bp_head_a", 64'(out_ops), 64'h0000_0011_0022_0033);
      step();
      chk("bp_hold_a", 64'(out_ops), 64'h0000_0011_0022_0033);
      chk("bp_hold_occ", 64'(occupancy), 64'd2);
      out_ready = 1;
      step();
      $display("bp: after pop A head=%h mode=%b", out_ops, out_mode);
      chk("bp_head_b", 64'(out_ops), 64'h0000_0004_0005_0006);
      chk("bp_mode_b", 64'(out_mode), 64'(6'b11_01_00));
      step();
      in_valid = 0;
      $display("bp: after pop B head=%h", out_ops);
      chk("bp_head_c", 64'(out_ops), 64'h0000_FF80_007F_0001);
      step();
      chk("bp_drained", 64'(occupancy), 64'd0);

      // Sustained push+pop at count 1
      in_valid = 1; in_optype = 3'b011; in_ops = 24'h12_34_56;
      step();
      p0 = dut_pops;
      for (int i = 0; i < 20; i++) begin
         in_optype = 3'($urandom);
         in_ops    = 24'($urandom);
         step();
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      $display("stream: pops over 20 cycles=%0d", dut_pops - p0);
      chk("stream_pops", 64'(dut_pops - p0), 64'd20);
      in_valid = 0;
      step();
      out_ready = 0;

      // Asynchronous reset with two entries buffered
      in_valid = 1; in_optype = 3'b111; in_ops = 24'hAA_BB_CC;
      step();
      in_ops = 24'h01_02_03;
      step();
      in_valid = 0;
      chk("mr_full", 64'(occupancy), 64'd2);
      #1;
      rst_n = 0;
      #1;
      $display("midreset: out_valid=%0d occupancy=%0d in_ready=%0d", out_valid, occupancy, in_ready);
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_occupancy", 64'(occupancy), 64'd0);
      chk("mr_in_ready", 64'(in_ready), 64'd1);
      chk("mr_out_ops", 64'(out_ops), 64'd0);
      step();
      rst_n = 1;
      step();
      out_ready = 1; in_valid = 1; in_optype = 3'b000; in_ops = 24'h01_02_FF;
      step();
      in_valid = 0;
      $display("post-reset push: out_valid=%0d out_ops=%h", out_valid, out_ops);
      chk("pr_valid", 64'(out_valid), 64'd1);
      chk("pr_ops", 64'(out_ops), 64'h0000_0001_0002_FFFF);
      step();

      // Wide instance: sign extension, mode 3, range check at NUM_REGS=40
      b_in_valid = 1; b_in_optype = 4'b1110;
      b_in_ops = {10'h027, 10'h02A, 10'h3FF, 10'h200};
      step();
      b_in_valid = 0;
      $display("wide: out_ops=%h mode=%b regerr=%b", b_out_ops, b_out_mode, b_out_regerr);
      chk("w_valid", 64'(b_out_valid), 64'd1);
      chk("w_imm200", 64'(b_out_ops[31:0]), 64'hFFFF_FE00);
      chk("w_reg3ff", 64'(b_out_ops[63:32]), 64'h0000_00FF);
      chk("w_reg2a", 64'(b_out_ops[95:64]), 64'h0000_002A);
      chk("w_reg27", 64'(b_out_ops[127:96]), 64'h0000_0027);
      chk("w_mode", 64'(b_out_mode), 64'(8'b00_00_11_00));
      chk("w_regerr", 64'(b_out_regerr), 64'(4'b0110));
      chk("w_isreg", 64'(b_out_isreg), 64'(4'b1110));
      for (int i = 0; i < 4; i++) begin
         ext_model(10, 32, 40, int'(b_in_ops[i*10 +: 10]), b_in_optype[i], x, m, r);
         chk("w_model_ext", 64'(b_out_ops[i*32 +: 32]), 64'(x));
         chk("w_model_mode", 64'(b_out_mode[i*2 +: 2]), 64'(m[1:0]));
         chk("w_model_err", 64'(b_out_regerr[i]), 64'(r));
      end
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
